// File: rtl/simple_adder_v.sv
`default_nettype none
// ============================================================================
// Module      : simple_adder_v
// Description : Single-stage registered unsigned adder with valid/ready
//               handshake on both sides. Produces the W-bit sum plus carry,
//               signed-overflow and zero flags, one clock after acceptance.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W          operand/result width in bits (2..64), default 8
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   x_0, x_1   unsigned operands (W bits)
//   in_valid   operands valid this cycle
//   in_ready   block accepts operands this cycle
//   result     registered sum (W bits)
//   carry      unsigned carry-out of the add
//   ovf        two's-complement overflow of the add
//   zero       registered result is all zeros
//   out_valid  result/flags hold a valid sample
//   out_ready  downstream consumes the output this cycle
// Configuration macro
//   SIMPLE_ADDER_SAT_EN  when defined, a carry-out saturates the registered
//                        result to all ones; carry still reports 1 and zero
//                        reflects the saturated value.
// ============================================================================
module simple_adder_v #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] x_1,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W:0]   sum_full;
  logic [W-1:0] sum_res;
  logic         sum_ovf;
  logic         in_xfer;
  logic         out_xfer;

  logic [W-1:0] result_d,    result_q;
  logic         carry_d,     carry_q;
  logic         ovf_d,       ovf_q;
  logic         zero_d,      zero_q;
  logic         out_valid_d, out_valid_q;

  // The output register can take a new sample whenever it is empty or is
  // being drained in this same cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    sum_full = {1'b0, x_0} + {1'b0, x_1};
    // Overflow is judged on the wrapped sum, before any saturation.
    sum_ovf  = (x_0[W-1] == x_1[W-1]) && (sum_full[W-1] != x_0[W-1]);
`ifdef SIMPLE_ADDER_SAT_EN
    sum_res  = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
    sum_res  = sum_full[W-1:0];
`endif

    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    // Operands only influence state through this branch, so undriven or
    // unknown operands while in_valid is low never reach the registers.
    if (in_xfer) begin
      result_d    = sum_res;
      carry_d     = sum_full[W];
      ovf_d       = sum_ovf;
      zero_d      = (sum_res == '0);
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      // Flags and result keep their last values; only the valid drops.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_simple_adder_v.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_adder_v
// Description : Self-checking bench for simple_adder_v (W=8): table-driven
//               directed vectors plus hand-written handshake/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_adder_v;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x_0, x_1;
  logic         in_valid, in_ready;
  logic [W-1:0] result;
  logic         carry, ovf, zero, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  simple_adder_v #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_0       (x_0),
    .x_1       (x_1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       o;
    logic       z;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] held;
    logic [8:0] full;
    logic [7:0] exp_r;

    // --- hand-computed vectors (wrapping build; saturating values in ifdef)
    vecs[0] = '{8'h24, 8'h81, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 8'h2A, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1'b0};
`ifdef SIMPLE_ADDER_SAT_EN
    vecs[5] = '{8'hFF, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'hC0, 8'hC0, 8'hFF, 1'b1, 1'b0, 1'b0};
`else
    vecs[5] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0, 1'b0};
`endif

    // --- reset state, including a pending input that must be ignored
    rst = 1'b1; x_0 = 8'h11; x_1 = 8'h22; in_valid = 1'b1; out_ready = 1'b0;
    #2;
    chk("rst_result",    result,    0);
    chk("rst_carry",     carry,     0);
    chk("rst_ovf",       ovf,       0);
    chk("rst_zero",      zero,      1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    tick();
    chk("rst_no_xfer",   out_valid, 0);
    rst = 1'b0;

    // --- first transfer on the first edge after reset release
    x_0 = 8'h24; x_1 = 8'h81; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("first_valid",  out_valid, 1);
    chk("first_result", result,    8'hA5);

    // --- table vectors back to back
    for (int i = 0; i < 8; i++) begin
      x_0 = vecs[i].a; x_1 = vecs[i].b; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      chk($sformatf("v%0d_valid", i),  out_valid, 1);
      chk($sformatf("v%0d_result", i), result,    vecs[i].res);
      chk($sformatf("v%0d_carry", i),  carry,     vecs[i].c);
      chk($sformatf("v%0d_ovf", i),    ovf,       vecs[i].o);
      chk($sformatf("v%0d_zero", i),   zero,      vecs[i].z);
    end

    // --- backpressure: load A5, stall 3 cycles while inputs change
    x_0 = 8'h24; x_1 = 8'h81; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x_0 = 8'h10 + 8'(k); x_1 = 8'h01;
      #1;
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      tick();
      chk($sformatf("bp%0d_result", k), result,    8'hA5);
      chk($sformatf("bp%0d_valid", k),  out_valid, 1);
      chk($sformatf("bp%0d_zero", k),   zero,      0);
    end
    // simultaneous drain and refill
    x_0 = 8'h03; x_1 = 8'h04; out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    chk("bp_refill_result", result,    8'h07);
    chk("bp_refill_valid",  out_valid, 1);

    // --- drain without refill: valid drops, data holds
    in_valid = 1'b0;
    tick();
    chk("drain_valid",  out_valid, 0);
    chk("drain_result", result,    8'h07);

    // --- unknown operands with in_valid low leave state untouched
    x_0 = 'x; x_1 = 'x;
    tick();
    chk("xin_valid",  out_valid, 0);
    chk("xin_result", result,    8'h07);
    chk("xin_zero",   zero,      0);

    // --- random back-to-back stream
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      x_0 = 8'($urandom_range(0, 255));
      x_1 = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      full = {1'b0, x_0} + {1'b0, x_1};
`ifdef SIMPLE_ADDER_SAT_EN
      exp_r = full[8] ? 8'hFF : full[7:0];
`else
      exp_r = full[7:0];
`endif
      tick();
      chk($sformatf("rnd%0d_valid", n),  out_valid, 1);
      chk($sformatf("rnd%0d_result", n), result,    exp_r);
      chk($sformatf("rnd%0d_carry", n),  carry,     full[8]);
    end
    in_valid = 1'b0;
    tick();
    chk("rnd_no_dup", out_valid, 0);

    // --- asynchronous reset mid-operation with a held sample
    x_0 = 8'h24; x_1 = 8'h81; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    held = result;
    chk("pre_areset_valid",  out_valid, 1);
    chk("pre_areset_result", held,      8'hA5);
    #2 rst = 1'b1;
    #1;
    chk("areset_valid",  out_valid, 0);
    chk("areset_result", result,    0);
    chk("areset_zero",   zero,      1);
    chk("areset_carry",  carry,     0);
    #1 rst = 1'b0;
    x_0 = 8'h7F; x_1 = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("post_areset_result", result,    8'h80);
    chk("post_areset_ovf",    ovf,       1);
    chk("post_areset_valid",  out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simple_adder_v.md
SIMPLE_ADDER_V -- requirements
Module: simple_adder_v

Interface
REQ-001 Parameter W, default 8: operand and result width in bits, legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 x_0  input  W  first operand, unsigned.
REQ-005 x_1  input  W  second operand, unsigned.
REQ-006 in_valid  input  1  operands valid this cycle.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 result  output  W  registered sum.
REQ-009 carry  output  1  unsigned carry-out of the add.
REQ-010 ovf  output  1  two's-complement signed overflow of the add.
REQ-011 zero  output  1  high when result is all zeros.
REQ-012 out_valid  output  1  result/flags hold a valid sample.
REQ-013 out_ready  input  1  downstream consumes the output this cycle.

Function
REQ-014 Input transfer when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready at a rising edge.
REQ-015 in_ready = !out_valid || out_ready (combinational); a new sample is accepted in the same cycle as the old one is consumed.
REQ-016 On input transfer: {carry, sum} = x_0 + x_1 computed at W+1 bits; result, carry, ovf, zero and out_valid=1 are registered; latency exactly 1 clock.
REQ-017 ovf = (x_0[W-1] == x_1[W-1]) && (sum[W-1] != x_0[W-1]), using the unsaturated sum.
REQ-018 zero is derived from the registered result value (after saturation when enabled).
REQ-019 Output transfer without a simultaneous input transfer clears out_valid; result and flags hold their last values.
REQ-020 While out_valid && !out_ready, result, carry, ovf, zero are held stable and in_ready is low; inputs are ignored.
REQ-021 Wrap-around: without saturation, sum is modulo 2^W (e.g. 8'hFF + 8'h01 = 8'h00, carry=1, zero=1).
REQ-022 Operands are not sampled when in_valid is low; X on unused inputs has no effect on state.

Reset
REQ-023 rst high asynchronously forces result=0, carry=0, ovf=0, zero=1, out_valid=0 regardless of clk.
REQ-024 While rst is high, in_ready=1 is driven but no transfer occurs; a sample pending at reset assertion is discarded.
REQ-025 The first input transfer is possible on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro SIMPLE_ADDER_SAT_EN defined: when carry=1, registered result is forced to all ones (2^W-1); carry still reports 1; zero evaluated on the saturated value.
REQ-027 Macro SIMPLE_ADDER_SAT_EN undefined: result is the wrapped W-bit sum; no saturation logic present.

Verification
REQ-028 Reset: assert rst mid-operation with out_valid=1 -> out_valid=0, result=0, zero=1 immediately, without a clock edge.
REQ-029 Basic add W=8: x_0=8'h24, x_1=8'h81, in_valid=1, out_ready=1 -> next cycle result=8'hA5, carry=0, ovf=0, zero=0, out_valid=1.
REQ-030 Wrap: x_0=8'hFF, x_1=8'h01 -> result=8'h00, carry=1, ovf=0, zero=1; with SIMPLE_ADDER_SAT_EN -> result=8'hFF, carry=1, zero=0.
REQ-031 Signed overflow: x_0=8'h7F, x_1=8'h01 -> result=8'h80, carry=0, ovf=1.
REQ-032 Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, result held across 3 cycles while inputs change; out_ready=1 with in_valid=1 -> new sample registered same edge, out_valid stays 1.
REQ-033 Random stream: 10 random operand pairs back-to-back, out_ready=1 -> each result equals (x_0+x_1) mod 256 one cycle after acceptance, no dropped or duplicated samples.
